// File: rtl/xdma_st_gen_sequencer.sv
// Run controller between the XDMA stream generator and the C2H stream slave.
// Gates the AXIS handshake to a programmed packet count with idle gaps between packets.
//
// state | meaning
// IDLE  | no run active, stream blocked
// RUN   | stream passes; packet boundaries evaluated on TLAST handshakes
// GAP   | stream blocked for the programmed number of idle cycles
module xdma_st_gen_sequencer #(
    parameter int C_AXIS_TDATA_WIDTH = 128
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESETN,
    input  logic                            ctrl_start,
    input  logic                            ctrl_abort,
    input  logic [1:0]                      cfg_mode,
    input  logic [63:0]                     cfg_step,
    input  logic [31:0]                     cfg_num_pkts,
    input  logic [15:0]                     cfg_gap,
    output logic [31:0]                     gen_config_reg0,
    output logic [31:0]                     gen_config_reg1,
    output logic [31:0]                     gen_config_reg2,
    input  logic                            S_AXIS_TVALID,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic                            M_AXIS_TVALID,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    output logic                            sts_busy,
    output logic                            sts_done,
    output logic [31:0]                     sts_pkt_cnt,
    output logic [31:0]                     sts_beat_cnt,
    output logic [31:0]                     sts_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [63:0] step_q, step_d;
    logic [31:0] num_pkts_q, num_pkts_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        abort_pend_q, abort_pend_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        pass;
    logic        hs;
    logic [31:0] pkt_inc;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Pass only depends on registered state, so ctrl/cfg never reach the stream combinationally.
    assign pass          = (state_q == ST_RUN);
    assign M_AXIS_TVALID = S_AXIS_TVALID & pass;
    assign S_AXIS_TREADY = M_AXIS_TREADY & pass;
    assign M_AXIS_TDATA  = S_AXIS_TDATA;
    assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
    assign M_AXIS_TLAST  = S_AXIS_TLAST;
    assign hs            = M_AXIS_TVALID & M_AXIS_TREADY;
    assign pkt_inc       = sat_inc(pkt_cnt_q);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        step_d       = step_q;
        num_pkts_d   = num_pkts_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        abort_pend_d = abort_pend_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pkt_cnt_d    = pkt_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        stall_cnt_d  = stall_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    mode_d       = cfg_mode;
                    step_d       = cfg_step;
                    num_pkts_d   = cfg_num_pkts;
                    gap_d        = cfg_gap;
                    pkt_cnt_d    = 32'd0;
                    beat_cnt_d   = 32'd0;
                    stall_cnt_d  = 32'd0;
                    abort_pend_d = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (M_AXIS_TVALID && !M_AXIS_TREADY) begin
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end
                if (hs) begin
                    beat_cnt_d = sat_inc(beat_cnt_q);
                end
                // The run may only end on a TLAST handshake, so TVALID is never withdrawn mid-beat.
                if (hs && S_AXIS_TLAST) begin
                    pkt_cnt_d = pkt_inc;
                    if (abort_pend_q || ctrl_abort ||
                        ((num_pkts_q != 32'd0) && (pkt_inc == num_pkts_q))) begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        abort_pend_d = 1'b0;
                    end else if (gap_q != 16'd0) begin
                        gap_cnt_d = gap_q;
                        state_d   = ST_GAP;
                    end
                end else if (ctrl_abort) begin
                    abort_pend_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (ctrl_abort) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    abort_pend_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                    if (gap_cnt_q == 16'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'd0;
            step_q       <= 64'd0;
            num_pkts_q   <= 32'd0;
            gap_q        <= 16'd0;
            gap_cnt_q    <= 16'd0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pkt_cnt_q    <= 32'd0;
            beat_cnt_q   <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            step_q       <= step_d;
            num_pkts_q   <= num_pkts_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pkt_cnt_q    <= pkt_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign gen_config_reg0 = {30'd0, mode_q};
    assign gen_config_reg1 = step_q[31:0];
    assign gen_config_reg2 = step_q[63:32];
    assign sts_busy        = busy_q;
    assign sts_done        = done_q;
    assign sts_pkt_cnt     = pkt_cnt_q;
    assign sts_beat_cnt    = beat_cnt_q;
    assign sts_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_xdma_st_gen_sequencer.sv
// Self-checking bench: random generator stream, scoreboard on passed beats,
// and a packet/gap-level reference model for pass, stalls and run end.
module tb_xdma_st_gen_sequencer;
    localparam int W  = 128;
    localparam int SW = W / 8;
    localparam int MEM_N = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ctrl_start = 1'b0, ctrl_abort = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [63:0]   cfg_step = '0;
    logic [31:0]   cfg_num_pkts = '0;
    logic [15:0]   cfg_gap = '0;
    logic [31:0]   gen_config_reg0, gen_config_reg1, gen_config_reg2;
    logic          S_TVALID = 1'b0;
    logic [W-1:0]  S_TDATA = '0;
    logic [SW-1:0] S_TSTRB = '0;
    logic          S_TLAST = 1'b0;
    logic          S_AXIS_TREADY;
    logic          M_AXIS_TVALID;
    logic [W-1:0]  M_AXIS_TDATA;
    logic [SW-1:0] M_AXIS_TSTRB;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY = 1'b0;
    logic          sts_busy, sts_done;
    logic [31:0]   sts_pkt_cnt, sts_beat_cnt, sts_stall_cnt;

    always #5 clk = ~clk;

    xdma_st_gen_sequencer #(.C_AXIS_TDATA_WIDTH(W)) dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n),
        .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step),
        .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap),
        .gen_config_reg0(gen_config_reg0), .gen_config_reg1(gen_config_reg1),
        .gen_config_reg2(gen_config_reg2),
        .S_AXIS_TVALID(S_TVALID), .S_AXIS_TDATA(S_TDATA), .S_AXIS_TSTRB(S_TSTRB),
        .S_AXIS_TLAST(S_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_pkt_cnt(sts_pkt_cnt),
        .sts_beat_cnt(sts_beat_cnt), .sts_stall_cnt(sts_stall_cnt)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] strb;
        logic          last;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] mem[MEM_N];
    int tests = 0, fails = 0, cyc = 0;

    // generator
    int gidx = 0, gpos = 0, glen = 1, vprob = 100;
    bit gen_on = 0, rdy_rand = 0;
    // reference model (packet/gap level)
    bit m_on = 0, m_abort = 0;
    int m_gap = 0, m_pkts = 0, m_n = 0, m_g = 0, m_stall = 0, m_err = 0;
    // timing probes
    int t_last = -1, first_hs = -1, start_cyc = 0, idle_run = 0, last_idle = 0;
    bit first_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (rst_n && M_AXIS_TVALID && M_AXIS_TREADY) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got beat %h with nothing expected", M_AXIS_TDATA);
            end else begin
                e = sb_q.pop_front();
                if (e.data !== M_AXIS_TDATA || e.strb !== M_AXIS_TSTRB || e.last !== M_AXIS_TLAST) begin
                    fails++;
                    $display("FAIL sb_beat: got %h/%h/%0d expected %h/%h/%0d",
                             M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, e.data, e.strb, e.last);
                end
            end
        end
    endtask

    task automatic drive_gen();
        logic [W-1:0] d;
        d       = mem[gidx % MEM_N];
        S_TDATA = d;
        S_TSTRB = d[SW-1:0] ^ 16'h5A5A;
        S_TLAST = (gpos == glen - 1);
    endtask

    task automatic gen_restart(input int len);
        gen_on   = 1;
        glen     = len;
        gpos     = 0;
        S_TVALID = 1'b0;
        drive_gen();
    endtask

    task automatic tick();
        bit hs_s, mp;
        @(negedge clk);
        hs_s = S_TVALID && S_AXIS_TREADY;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (!first_seen) begin
                first_seen = 1;
                first_hs   = cyc;
            end
            if (M_AXIS_TLAST) t_last = cyc;
        end
        if (sts_busy && !M_AXIS_TVALID) idle_run++;
        else if (M_AXIS_TVALID) begin
            if (idle_run > 0) last_idle = idle_run;
            idle_run = 0;
        end
        mp = m_on && (m_gap == 0);
        if (rst_n) begin
            if (M_AXIS_TVALID !== (S_TVALID && mp)) m_err++;
            if (mp && S_TVALID && !M_AXIS_TREADY) m_stall++;
            if (m_on && m_gap != 0) begin
                if (ctrl_abort) begin
                    m_on  = 0;
                    m_gap = 0;
                end else m_gap--;
            end else if (mp) begin
                if (S_TVALID && M_AXIS_TREADY && S_TLAST) begin
                    m_pkts++;
                    if (m_abort || ctrl_abort || (m_n != 0 && m_pkts == m_n)) begin
                        m_on    = 0;
                        m_abort = 0;
                    end else m_gap = m_g;
                end else if (ctrl_abort) m_abort = 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (hs_s) begin
            gidx++;
            gpos = (gpos == glen - 1) ? 0 : gpos + 1;
        end
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        if (!S_TVALID || hs_s) S_TVALID = gen_on && ($urandom_range(99) < vprob);
        M_AXIS_TREADY = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
        drive_gen();
    endtask

    // Generator must be at a packet boundary; exp_pkts whole packets are expected to pass.
    task automatic start_run(input int n, input int g, input int exp_pkts);
        exp_t e;
        logic [W-1:0] d;
        for (int i = 0; i < exp_pkts * glen; i++) begin
            d      = mem[(gidx + i) % MEM_N];
            e.data = d;
            e.strb = d[SW-1:0] ^ 16'h5A5A;
            e.last = ((i % glen) == glen - 1);
            sb_q.push_back(e);
        end
        cfg_num_pkts = n;
        cfg_gap      = g;
        ctrl_start   = 1'b1;
        first_seen   = 0;
        idle_run     = 0;
        last_idle    = 0;
        start_cyc    = cyc;
        tick();
        m_on = 1; m_abort = 0; m_gap = 0; m_pkts = 0; m_n = n; m_g = g;
        m_stall = 0; m_err = 0;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        do begin
            tick();
            k++;
        end while (sts_busy && k < bound);
        chk("run_end_timeout", sts_busy, 0);
    endtask

    task automatic end_checks(input int pkts, input int beats);
        chk("pkt_cnt", sts_pkt_cnt, pkts);
        chk("beat_cnt", sts_beat_cnt, beats);
        chk("stall_cnt", sts_stall_cnt, m_stall);
        chk("pass_vs_model", m_err, 0);
        chk("done", sts_done, 1);
        chk("sb_left", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, g, len;
        for (int i = 0; i < MEM_N; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // reset values
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        S_TVALID = 1'b1;
        M_AXIS_TREADY = 1'b1;
        #1;
        chk("rst_busy", sts_busy, 0);
        chk("rst_done", sts_done, 0);
        chk("rst_reg0", gen_config_reg0, 0);
        chk("rst_reg1", gen_config_reg1, 0);
        chk("rst_tvalid_idle", M_AXIS_TVALID, 0);
        chk("rst_tready_idle", S_AXIS_TREADY, 0);
        tick();

        // 3 packets x 64 beats, back-to-back
        cfg_mode = 2'd1;
        cfg_step = 64'h0123_4567_89AB_CDEF;
        gen_restart(64);
        start_run(3, 0, 3);
        chk("start_reg0", gen_config_reg0, 1);
        chk("start_reg1", gen_config_reg1, 32'h89AB_CDEF);
        chk("start_reg2", gen_config_reg2, 32'h0123_4567);
        chk("start_busy", sts_busy, 1);
        chk("start_done", sts_done, 0);
        wait_idle(1000);
        chk("first_beat_cycle", first_hs, start_cyc + 1);
        chk("done_after_tlast", cyc, t_last + 1);
        chk("no_gap_b2b", last_idle, 0);
        chk("tready_after_run", S_AXIS_TREADY, 0);
        end_checks(3, 192);

        // gap of 5
        gen_restart(16);
        start_run(2, 5, 2);
        wait_idle(1000);
        chk("gap5_idle_cycles", last_idle, 5);
        end_checks(2, 32);

        // abort mid-packet, unlimited run
        gen_restart(16);
        start_run(0, 2, 1);
        repeat (5) tick();
        ctrl_abort = 1'b1;
        tick();
        wait_idle(500);
        end_checks(1, 16);

        // abort during gap
        gen_restart(8);
        t_last = -1;
        start_run(0, 10, 1);
        k = 0;
        while (t_last < 0 && k < 200) begin
            tick();
            k++;
        end
        chk("gap_abort_tlast_seen", (t_last >= 0), 1);
        ctrl_abort = 1'b1;
        tick();
        chk("gap_abort_busy", sts_busy, 0);
        chk("gap_abort_done", sts_done, 1);
        end_checks(1, 8);

        // random valid / ready
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(8, 1);
            n   = $urandom_range(4, 1);
            g   = $urandom_range(3, 0);
            gen_restart(len);
            vprob    = 60;
            rdy_rand = 1;
            start_run(n, g, n);
            wait_idle(3000);
            end_checks(n, n * len);
        end
        vprob    = 100;
        rdy_rand = 0;
        tick();

        // config held across a run; restart while busy ignored
        cfg_mode = 2'd2;
        cfg_step = 64'hDEAD_BEEF_0000_0011;
        gen_restart(6);
        start_run(3, 1, 3);
        repeat (4) tick();
        cfg_mode   = 2'd3;
        cfg_step   = 64'h1111_2222_3333_4444;
        ctrl_start = 1'b1;
        tick();
        chk("hold_reg0", gen_config_reg0, 2);
        chk("hold_reg1", gen_config_reg1, 32'h0000_0011);
        chk("hold_reg2", gen_config_reg2, 32'hDEAD_BEEF);
        chk("hold_beats_not_cleared", sts_beat_cnt, 5);
        wait_idle(500);
        end_checks(3, 18);

        // start and abort together in IDLE: start proceeds, abort ignored
        gen_restart(3);
        ctrl_abort = 1'b1;
        start_run(2, 0, 2);
        chk("new_reg0", gen_config_reg0, 3);
        chk("new_reg1", gen_config_reg1, 32'h3333_4444);
        chk("new_reg2", gen_config_reg2, 32'h1111_2222);
        chk("new_done_clr", sts_done, 0);
        wait_idle(500);
        end_checks(2, 6);

        // asynchronous reset mid-beat
        gen_restart(20);
        start_run(0, 0, 1);
        repeat (4) tick();
        chk("pre_reset_tvalid", M_AXIS_TVALID, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", M_AXIS_TVALID, 0);
        chk("arst_tready", S_AXIS_TREADY, 0);
        chk("arst_busy", sts_busy, 0);
        chk("arst_done", sts_done, 0);
        chk("arst_pkt", sts_pkt_cnt, 0);
        chk("arst_beat", sts_beat_cnt, 0);
        chk("arst_stall", sts_stall_cnt, 0);
        chk("arst_reg0", gen_config_reg0, 0);
        chk("arst_reg1", gen_config_reg1, 0);
        chk("arst_reg2", gen_config_reg2, 0);
        sb_q.delete();
        m_on = 0; m_gap = 0; m_abort = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        gen_restart(4);
        tick();
        start_run(1, 0, 1);
        wait_idle(200);
        end_checks(1, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
